keypad_scanner: RTL
===================

# keypad_scanner

4×4 matrix keypad scanner for the board's front-panel input path. It is the input-side counterpart of the six-digit LED display driver. It drives one-hot active-low row selects at a divided scan rate and samples the active-low column returns. It debounces whole-matrix scans and delivers each accepted keypress as a 4-bit hex code through a valid/ack holding register. Codes map directly onto the 0–F glyph set the display driver renders.

## Interface
- CLK_DIV, 16'd49999: tick period minus one, in clk cycles (50 MHz → 1 kHz row tick).
- DEBOUNCE_SCANS, 8'd20: consecutive identical full scans needed to accept a press or release; legal range 2–255.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- col_in  input  [3:0]  column returns, active-low, externally pulled up.
- key_ack  input  1  consumer acknowledge; pulse high for one cycle.
- row_out  output  [3:0]  row select, one-hot active-low, registered.
- key_code  output  [3:0]  latched code of the last accepted press, equal to {row[1:0], col[1:0]}.
- key_valid  output  1  high while an unacknowledged code is held.
- key_down  output  1  high while the debounced state is PRESSED.
- overrun  output  1  sticky; set when a press is dropped because key_valid was still high.

## Operation
- **Tick:** tick_cnt counts 0..CLK_DIV. A tick occurs in the cycle where tick_cnt == CLK_DIV, then tick_cnt wraps to 0.
- **Row scan:** row index r runs 0→1→2→3→0 and advances only on a tick. row_out = ~(1<<r). On each tick, col_in is sampled for the current r, then r advances. Each row is therefore held for a full tick period before its columns are sampled.
- **Scan accumulation:** across the 4 ticks, count the active (0) column bits and record the {r, c} of the pressed key.
- **Scan classification:** on the tick that samples r=3, classify the scan:
  - NONE: no active bits.
  - SINGLE(code): exactly one active bit.
  - MULTI: two or more active bits.
- **Debounce:** keep prev_cand and stab_cnt (8-bit).
  - At end of scan, if cand == prev_cand (class and code both equal), stab_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise stab_cnt <= 1 and prev_cand <= cand.
  - A stable event fires when stab_cnt steps from DEBOUNCE_SCANS-1 to DEBOUNCE_SCANS.
- **FSM, two states: IDLE and PRESSED.**
  - IDLE + stable event SINGLE → PRESSED, and a press is issued.
  - IDLE + stable event NONE or MULTI → stay in IDLE.
  - PRESSED + stable event NONE → IDLE (release, no output event).
  - PRESSED + stable event SINGLE or MULTI → stay in PRESSED. A new key is only accepted after a release.
  - key_down = (state == PRESSED).
- **Press issue:**
  - If key_valid is 0, or key_ack is high in the same cycle: key_code <= code and key_valid <= 1.
  - Otherwise key_code is unchanged, key_valid stays 1, and overrun <= 1.
- **Ack:**
  - key_ack with key_valid = 1 and no simultaneous press: key_valid <= 0 and overrun <= 0.
  - key_ack with key_valid = 0: ignored.

## Timing
- **Reset values:**
  - Outputs: row_out = 4'b1110, key_code = 0, key_valid = 0, key_down = 0, overrun = 0.
  - Internal: tick_cnt = 0, r = 0, state = IDLE, prev_cand = NONE, stab_cnt = DEBOUNCE_SCANS (saturated, so no spurious release after reset).
- **Reset mid-operation:** all state returns to the reset values on the next clock edge; any scan in progress is discarded. A key still held after reset is re-detected as a fresh press.
- **Scan rate:**
  - One full scan = 4·(CLK_DIV+1) cycles.
  - Minimum press latency = DEBOUNCE_SCANS full scans of stable SINGLE.
  - key_valid and key_down rise in the cycle after the final tick of the accepting scan.
- **Handshake rules:**
  - key_code is stable whenever key_valid = 1.
  - key_valid falls in the cycle after key_ack.
  - When ack and press occur in the same cycle, key_valid stays high with the new code.

## Test plan
Use CLK_DIV=3 (tick every 4 clk, scan = 16 clk) and DEBOUNCE_SCANS=3. The bench matrix model drives col c low while row_out[r]=0 for each held key (r, c).
- **Reset:** release rst → all outputs at their reset values, and row_out steps 1110→1101→1011→0111→1110, changing every 4 clk.
- **Single key:** hold key (2,1) → after 3 stable scans, key_valid=1, key_code=4'h9, key_down=1. Pulse key_ack → key_valid=0 next cycle. Release → key_down=0 after 3 NONE scans, with no new key_valid.
- **Bounce:** toggle key (0,3) every scan for 10 scans → key_valid and key_down stay 0 throughout.
- **Ghosting:** hold keys (0,0) and (3,3) together → MULTI scans only, state stays IDLE, key_valid=0.
- **Overrun:** press/release 4'h5, then press/release 4'h7 with no ack → key_code=5, overrun=1. Pulse key_ack → key_valid=0 and overrun=0. A same-cycle ack+press loads 4'h7 with key_valid held at 1.
- **Reset while PRESSED:** hold key (1,2), assert rst for 1 cycle → outputs at reset values next cycle. Key_valid rises again with key_code=4'h6 after 3 further scans.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner.
// Drives one-hot active-low row selects on a divided tick and samples the
// column returns. Whole-matrix scans are debounced before a press or release
// is accepted. Accepted presses are delivered through a valid/ack register.
module keypad_scanner #(
  parameter logic [15:0] CLK_DIV        = 16'd49999,
  parameter logic [7:0]  DEBOUNCE_SCANS = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  input  logic       key_ack,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);

  typedef enum logic [1:0] {
    CAND_NONE   = 2'd0,
    CAND_SINGLE = 2'd1,
    CAND_MULTI  = 2'd2
  } cand_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESSED = 1'b1
  } state_e;

  // Tick generation and row sequencing
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  row_out_q, row_out_d;
  logic        tick;
  logic        scan_end;

  // Per-scan accumulation: hit count saturates at 2 (only 0/1/many matter)
  logic [1:0]  hits_q, hits_d;
  logic [3:0]  hit_code_q, hit_code_d;
  logic [2:0]  row_hits;
  logic [1:0]  row_col;
  logic        row_found;
  logic [2:0]  total_hits;
  logic [3:0]  scan_code;

  // Classified candidate for the scan that ends on this tick
  cand_e       cand_cls;
  logic [3:0]  cand_code;

  // Debounce state
  cand_e       prev_cls_q, prev_cls_d;
  logic [3:0]  prev_code_q, prev_code_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic        stable_evt;

  // Key state machine
  state_e      state_q, state_d;
  logic        press;

  // Output holding register
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        overrun_q, overrun_d;

  assign tick     = (tick_cnt_q == CLK_DIV);
  assign scan_end = tick && (row_idx_q == 2'd3);

  // Next tick counter value, row index and registered row select
  always_comb begin
    tick_cnt_d = tick_cnt_q + 16'd1;
    row_idx_d  = row_idx_q;
    if (tick) begin
      tick_cnt_d = '0;
      row_idx_d  = row_idx_q + 2'd1;
    end
    row_out_d = 4'b1111 ^ (4'b0001 << row_idx_d);
  end

  // Count active columns in the currently selected row; lowest column wins
  always_comb begin
    row_hits  = '0;
    row_col   = '0;
    row_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col_in[i]) begin
        row_hits = row_hits + 3'd1;
        if (!row_found) begin
          row_col   = 2'(i);
          row_found = 1'b1;
        end
      end
    end
  end

  // Fold this row into the scan totals and classify at the end of the scan
  always_comb begin
    total_hits = {1'b0, hits_q} + row_hits;
    scan_code  = (hits_q != 2'd0) ? hit_code_q : {row_idx_q, row_col};

    hits_d     = hits_q;
    hit_code_d = hit_code_q;
    if (scan_end) begin
      hits_d     = '0;
      hit_code_d = '0;
    end else if (tick) begin
      hits_d = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
      if (hits_q == 2'd0 && row_found) begin
        hit_code_d = {row_idx_q, row_col};
      end
    end

    // Code is forced to zero for NONE/MULTI so candidate compare is class-exact
    cand_cls  = CAND_NONE;
    cand_code = '0;
    if (total_hits == 3'd1) begin
      cand_cls  = CAND_SINGLE;
      cand_code = scan_code;
    end else if (total_hits >= 3'd2) begin
      cand_cls = CAND_MULTI;
    end
  end

  // Scan timing and accumulation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      row_idx_q  <= '0;
      row_out_q  <= 4'b1110;
      hits_q     <= '0;
      hit_code_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      row_idx_q  <= row_idx_d;
      row_out_q  <= row_out_d;
      hits_q     <= hits_d;
      hit_code_q <= hit_code_d;
    end
  end

  // Debounce: count consecutive identical scans, fire once on reaching the limit
  always_comb begin
    prev_cls_d  = prev_cls_q;
    prev_code_d = prev_code_q;
    stab_cnt_d  = stab_cnt_q;
    stable_evt  = 1'b0;
    if (scan_end) begin
      if (cand_cls == prev_cls_q && cand_code == prev_code_q) begin
        if (stab_cnt_q != DEBOUNCE_SCANS) begin
          stab_cnt_d = stab_cnt_q + 8'd1;
        end
        if (stab_cnt_q == DEBOUNCE_SCANS - 8'd1) begin
          stable_evt = 1'b1;
        end
      end else begin
        stab_cnt_d  = 8'd1;
        prev_cls_d  = cand_cls;
        prev_code_d = cand_code;
      end
    end
  end

  // Debounce registers; counter starts saturated so no event fires after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cls_q  <= CAND_NONE;
      prev_code_q <= '0;
      stab_cnt_q  <= DEBOUNCE_SCANS;
    end else begin
      prev_cls_q  <= prev_cls_d;
      prev_code_q <= prev_code_d;
      stab_cnt_q  <= stab_cnt_d;
    end
  end

  // Press/release state machine: new key accepted only after a stable release
  always_comb begin
    state_d = state_q;
    press   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stable_evt && cand_cls == CAND_SINGLE) begin
          state_d = S_PRESSED;
          press   = 1'b1;
        end
      end
      S_PRESSED: begin
        if (stable_evt && cand_cls == CAND_NONE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding register: press loads unless an unacked code is held, ack clears
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (press) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = cand_code;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = (state_q == S_PRESSED);
  assign overrun   = overrun_q;

endmodule
